// File: rtl/uart_rx_ctrl_if.sv
// Bus between the UART receive buffer and its user: byte-in strobe, CPU pop/control, status out.
interface uart_rx_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     rx_dv;
    logic [7:0]               rx_byte;
    logic                     rd;
    logic                     clr_ovf;
    logic                     irq_en;
    logic [7:0]               rd_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     overrun;
    logic                     irq;

    modport master (
        output rx_dv, rx_byte, rd, clr_ovf, irq_en,
        input  rd_data, count, empty, full, overrun, irq
    );

    modport slave (
        input  rx_dv, rx_byte, rd, clr_ovf, irq_en,
        output rd_data, count, empty, full, overrun, irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive FIFO with overrun, threshold irq and optional idle timeout.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-timeout counter.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned THRESHOLD    = 8,
    parameter int unsigned TIMEOUT_CLKS = 500
) (
    input  logic          i_Clock,
    input  logic          reset_n,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || THRESHOLD < 1 || THRESHOLD > DEPTH ||
        TIMEOUT_CLKS < 2) begin : g_param_err
        $error("uart_rx_ctrl: illegal parameter combination");
    end

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_timeout_flag;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = bus.rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push    = bus.rx_dv & (~w_full | bus.rd);
    assign w_ovf_set = bus.rx_dv & w_full & ~bus.rd;

    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_byte;
        end
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set has priority over clear.
            if (w_ovf_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

    logic [TW-1:0] r_idle_cnt;

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (bus.rx_dv || bus.rd || w_empty) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TW'(TIMEOUT_CLKS - 1)) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end
    end

    assign w_timeout_flag = (r_idle_cnt == TW'(TIMEOUT_CLKS - 1));
`else
    assign w_timeout_flag = 1'b0;
`endif

    assign bus.rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.count   = r_count;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.overrun = r_overrun;
    assign bus.irq     = bus.irq_en &
                         ((r_count >= CW'(THRESHOLD)) | r_overrun | w_timeout_flag);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: queue-based reference model, directed cases and random traffic.
module tb_uart_rx_ctrl;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned THRESHOLD    = 8;
    localparam int unsigned TIMEOUT_CLKS = 500;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(
        .DEPTH        (DEPTH),
        .THRESHOLD    (THRESHOLD),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .i_Clock (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue, sticky overrun, idle-cycle age.
    byte unsigned m_q[$];
    byte unsigned exp_q[$];
    bit           m_ovf;
    bit           m_en;
    int           m_idle;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, req);
        end
    endtask

    function automatic bit m_timeout();
`ifdef UART_RX_TIMEOUT_EN
        return m_idle >= int'(TIMEOUT_CLKS) - 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        int n;
        bit exp_irq;
        n = m_q.size();
        exp_irq = m_en && (n >= int'(THRESHOLD) || m_ovf || m_timeout());
        check("rd_data", int'(bus.rd_data), (n > 0) ? int'(m_q[0]) : 0);
        check("count", int'(bus.count), n);
        check("empty", int'(bus.empty), int'(n == 0));
        check("full", int'(bus.full), int'(n == int'(DEPTH)));
        check("overrun", int'(bus.overrun), int'(m_ovf));
        check("irq", int'(bus.irq), int'(exp_irq));
    endtask

    task automatic step(input bit dv, input byte unsigned b, input bit rd, input bit clr,
                        input bit en);
        int n;
        bit was_full;
        bit pop;
        @(negedge clk);
        check_outputs();
        bus.rx_dv   = dv;
        bus.rx_byte = b;
        bus.rd      = rd;
        bus.clr_ovf = clr;
        bus.irq_en  = en;
        n        = m_q.size();
        was_full = (n == int'(DEPTH));
        pop      = rd && (n > 0);
        if (pop) exp_q.push_back(m_q.pop_front());
        if (dv && (!was_full || pop)) m_q.push_back(b);
        if (dv && was_full && !rd) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (dv || rd || n == 0) m_idle = 0;
        else if (m_idle < int'(TIMEOUT_CLKS) - 1) m_idle++;
        m_en = en;
    endtask

    task automatic idle(input int cycles, input bit en);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b0, en);
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_idle = 0;
    endtask

    // Reset asserted between edges; outputs must drop at once and traffic must be ignored.
    task automatic reset_mid();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_rd_data", int'(bus.rd_data), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_irq", int'(bus.irq), 0);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = 8'h77;
        bus.rd      = 1'b1;
        repeat (2) @(negedge clk);
        bus.rx_dv = 1'b0;
        bus.rd    = 1'b0;
        rst_n     = 1'b1;
        model_reset();
    endtask

    // Monitor: every accepted pop must return the next byte the model expects.
    initial begin
        byte unsigned e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.rd && !bus.empty) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_data at %0t: actual=0x%0h required=no pop", $time,
                             bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd_data != e) begin
                        bad++;
                        $display("FAIL pop_data at %0t: actual=0x%0h required=0x%0h", $time,
                                 bus.rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int p_dv;
        int p_rd;
        rst_n       = 1'b0;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        bus.irq_en  = 1'b0;
        m_en        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single byte in and out.
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Fill, overrun, drain in order, clear overrun.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // Simultaneous write and read while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Simultaneous write and read while empty.
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Threshold irq.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Idle timeout (irq only when the timeout feature is built in).
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(int'(TIMEOUT_CLKS), 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
        reset_mid();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 6; ph++) begin
            p_dv = (ph % 2 == 0) ? 70 : 35;
            p_rd = (ph % 2 == 0) ? 30 : 65;
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(99) < p_dv), 8'($urandom_range(255)),
                     ($urandom_range(99) < p_rd), ($urandom_range(99) < 5),
                     1'($urandom_range(1)));
            end
        end
        idle(2, 1'b1);

        check("pending_pops", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
